// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter for a single-port memory with bus timeout
// All outputs are registered; a transfer is grant edge, ack edge, then one ACK cycle back to IDLE.
module mem_arbiter #(
   parameter int XLEN        = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            i_req_i,
   input  logic [XLEN-1:0] i_addr_i,
   output logic            i_ack_o,
   output logic [XLEN-1:0] i_rdata_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [XLEN-1:0] d_addr_i,
   input  logic [XLEN-1:0] d_wdata_i,
   output logic            d_ack_o,
   output logic [XLEN-1:0] d_rdata_o,
   output logic            err_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i,
   input  logic            mem_ack_i
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;
   localparam logic [1:0] ACK    = 2'd3;

   // A zero-width counter is illegal, so a disabled timeout keeps a single unused bit.
   localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

   logic [1:0]    state;
   logic          last_d;
   logic [CW-1:0] to_cnt;
   logic          grant_d;
   logic          grant_i;
   logic          timeout_hit;

   always_comb begin
      grant_d     = d_req_i && (!i_req_i || !last_d);
      grant_i     = i_req_i && !grant_d;
      timeout_hit = (TIMEOUT_CYC > 0) && (to_cnt == CNT_LAST);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         last_d      <= 1'b0;
         to_cnt      <= '0;
         i_ack_o     <= 1'b0;
         i_rdata_o   <= '0;
         d_ack_o     <= 1'b0;
         d_rdata_o   <= '0;
         err_o       <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               to_cnt <= '0;
               if (grant_d) begin
                  state       <= BUSY_D;
                  last_d      <= 1'b1;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= d_we_i;
                  mem_addr_o  <= d_addr_i;
                  mem_wdata_o <= d_wdata_i;
               end else if (grant_i) begin
                  state       <= BUSY_I;
                  last_d      <= 1'b0;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= i_addr_i;
                  mem_wdata_o <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               // A real ack on the timeout edge takes priority over the abort.
               if (mem_ack_i || timeout_hit) begin
                  state     <= ACK;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  err_o     <= !mem_ack_i;
                  if (state == BUSY_I) begin
                     i_ack_o   <= 1'b1;
                     i_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                  end else begin
                     d_ack_o   <= 1'b1;
                     d_rdata_o <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                  end
               end else if (TIMEOUT_CYC > 0) begin
                  to_cnt <= to_cnt + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               i_ack_o <= 1'b0;
               d_ack_o <= 1'b0;
               err_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule
